// File: rtl/nv_nvdla_core_reset_seq.sv
// Multi-domain core reset sequencer: merges reset sources, synchronises release to
// nvdla_clk, releases domains in staggered order and services per-domain soft resets.
module nv_nvdla_core_reset_seq #(
   parameter int unsigned NUM_DOMAINS = 3,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned MIN_ASSERT  = 4,
   parameter int unsigned RELEASE_GAP = 3
) (
   input  logic                   nvdla_clk,
   input  logic                   dla_reset_rstn,
   input  logic                   direct_reset_,
   input  logic                   core_reset_rstn,
   input  logic                   test_mode,
   input  logic [NUM_DOMAINS-1:0] sw_rst_req,
   output logic [NUM_DOMAINS-1:0] synced_rstn,
   output logic [NUM_DOMAINS-1:0] sw_rst_busy,
   output logic                   reset_done
);

   localparam int unsigned CNT_MAX   = (MIN_ASSERT > RELEASE_GAP) ? MIN_ASSERT : RELEASE_GAP;
   localparam int unsigned CW        = $clog2(CNT_MAX + 1);
   localparam int unsigned IW        = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
   // HOLD is entered one edge after sync_ok rises, so it runs two counts short
   localparam int unsigned HOLD_LAST = (MIN_ASSERT >= 2) ? (MIN_ASSERT - 2) : 0;

   typedef enum logic [1:0] {ST_RST, ST_HOLD, ST_RELEASE, ST_DONE} state_e;

   logic                   rst_comb;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_ok;

   state_e                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [NUM_DOMAINS-1:0] synced_q, synced_d;
   logic [NUM_DOMAINS-1:0] busy_q, busy_d;
   logic                   done_q, done_d;
   logic [CW-1:0]          scnt_q [NUM_DOMAINS];
   logic [CW-1:0]          scnt_d [NUM_DOMAINS];
   logic                   go_rel;

   assign rst_comb = test_mode ? direct_reset_
                               : (dla_reset_rstn & direct_reset_ & core_reset_rstn);

   // Release synchroniser; assertion is asynchronous through the clear
   always_ff @(posedge nvdla_clk or negedge rst_comb) begin
      if (!rst_comb) sync_q <= '0;
      else           sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
   end

   assign sync_ok = sync_q[SYNC_STAGES-1];

   always_ff @(posedge nvdla_clk or negedge rst_comb) begin
      if (!rst_comb) begin
         state_q  <= ST_RST;
         cnt_q    <= '0;
         idx_q    <= '0;
         synced_q <= '0;
         busy_q   <= '0;
         done_q   <= 1'b0;
         for (int unsigned i = 0; i < NUM_DOMAINS; i++) scnt_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         synced_q <= synced_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         for (int unsigned i = 0; i < NUM_DOMAINS; i++) scnt_q[i] <= scnt_d[i];
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      synced_d = synced_q;
      busy_d   = busy_q;
      done_d   = done_q;
      scnt_d   = scnt_q;
      go_rel   = 1'b0;

      case (state_q)
         ST_RST: begin
            if (sync_ok) begin
               cnt_d = '0;
               if (MIN_ASSERT == 1) go_rel  = 1'b1;
               else                 state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (cnt_q >= CW'(HOLD_LAST)) go_rel = 1'b1;
            else if (cnt_q != '1)        cnt_d  = cnt_q + CW'(1);
         end
         ST_RELEASE: begin
            if (cnt_q >= CW'(RELEASE_GAP - 1)) begin
               cnt_d = '0;
               idx_d = idx_q + IW'(1);
               for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
                  if (IW'(i) == idx_d) synced_d[i] = 1'b1;
               end
               if (idx_d == IW'(NUM_DOMAINS - 1)) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DONE: begin
            // Each domain runs its own soft-reset pulse; a held request re-arms once busy drops
            for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
               if (busy_q[i]) begin
                  if (scnt_q[i] >= CW'(MIN_ASSERT - 1)) begin
                     synced_d[i] = 1'b1;
                     busy_d[i]   = 1'b0;
                  end else if (scnt_q[i] != '1) begin
                     scnt_d[i] = scnt_q[i] + CW'(1);
                  end
               end else if (sw_rst_req[i]) begin
                  synced_d[i] = 1'b0;
                  busy_d[i]   = 1'b1;
                  scnt_d[i]   = '0;
               end
            end
         end
         default: state_d = ST_RST;
      endcase

      if (go_rel) begin
         synced_d[0] = 1'b1;
         idx_d       = '0;
         cnt_d       = '0;
         if (NUM_DOMAINS == 1) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
         end else begin
            state_d = ST_RELEASE;
         end
      end
   end

   // DFT bypass: in test mode every output follows direct_reset_
   assign synced_rstn = test_mode ? {NUM_DOMAINS{direct_reset_}} : synced_q;
   assign reset_done  = test_mode ? direct_reset_ : done_q;
   assign sw_rst_busy = test_mode ? '0 : busy_q;

endmodule

// File: tb/tb_nv_nvdla_core_reset_seq.sv
// Directed bench for nv_nvdla_core_reset_seq: default 3-domain instance plus a
// 1-domain / 3-stage / MIN_ASSERT=1 instance.
module tb_nv_nvdla_core_reset_seq;

   localparam int N  = 3;
   localparam int S  = 2;
   localparam int MA = 4;
   localparam int G  = 3;
   localparam int S6  = 3;
   localparam int MA6 = 1;

   logic       clk = 1'b0;
   logic       dla = 1'b1, direct = 1'b1, core = 1'b1, tm = 1'b0;
   logic [2:0] req = 3'b000;
   logic [2:0] synced, busy;
   logic       done;

   logic       dla6 = 1'b1, dir6 = 1'b1, core6 = 1'b1, tm6 = 1'b0, req6 = 1'b0;
   logic       s6, b6, d6;

   int         nchecks = 0;
   int         nerrs   = 0;
   logic [6:0] sbq [$];

   always #5 clk = ~clk;

   nv_nvdla_core_reset_seq #(
      .NUM_DOMAINS(N), .SYNC_STAGES(S), .MIN_ASSERT(MA), .RELEASE_GAP(G)
   ) u_dut (
      .nvdla_clk(clk), .dla_reset_rstn(dla), .direct_reset_(direct),
      .core_reset_rstn(core), .test_mode(tm), .sw_rst_req(req),
      .synced_rstn(synced), .sw_rst_busy(busy), .reset_done(done)
   );

   nv_nvdla_core_reset_seq #(
      .NUM_DOMAINS(1), .SYNC_STAGES(S6), .MIN_ASSERT(MA6), .RELEASE_GAP(3)
   ) u_dut6 (
      .nvdla_clk(clk), .dla_reset_rstn(dla6), .direct_reset_(dir6),
      .core_reset_rstn(core6), .test_mode(tm6), .sw_rst_req(req6),
      .synced_rstn(s6), .sw_rst_busy(b6), .reset_done(d6)
   );

   task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nerrs++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] obs_main();
      return {done, busy, synced};
   endfunction

   function automatic logic [6:0] obs6();
      return {4'b0000, d6, b6, s6};
   endfunction

   // Expected {done, busy, synced} at edge e after release of the combined reset
   function automatic logic [6:0] model_seq(input int e);
      logic [2:0] s;
      for (int i = 0; i < N; i++) s[i] = (e >= S + MA + i * G);
      return {(e >= S + MA + (N - 1) * G), 3'b000, s};
   endfunction

   function automatic logic [6:0] model6(input int e);
      logic r;
      r = (e >= S6 + MA6);
      return {4'b0000, r, 1'b0, r};
   endfunction

   task automatic seq_check(input string tag, input int e_from, input int e_to);
      for (int e = e_from; e <= e_to; e++) sbq.push_back(model_seq(e));
      for (int e = e_from; e <= e_to; e++) begin
         @(posedge clk); #1;
         check(tag, obs_main(), sbq.pop_front());
      end
   endtask

   task automatic seq6_check(input string tag, input int e_to);
      for (int e = 1; e <= e_to; e++) sbq.push_back(model6(e));
      for (int e = 1; e <= e_to; e++) begin
         @(posedge clk); #1;
         check(tag, obs6(), sbq.pop_front());
      end
   endtask

   // Soft-reset request held for hold edges; pulses start every MA+1 edges while held
   task automatic soft_check(input string tag, input logic [2:0] mask, input int hold, input int total);
      for (int k = 0; k < total; k++) begin
         logic low;
         low = 1'b0;
         for (int st = 0; st < hold; st += MA + 1)
            if (k >= st && k < st + MA) low = 1'b1;
         sbq.push_back(low ? {1'b1, mask, ~mask} : {1'b1, 3'b000, 3'b111});
      end
      @(negedge clk);
      req = mask;
      for (int k = 0; k < total; k++) begin
         @(posedge clk); #1;
         if (k == hold - 1) req = 3'b000;
         check(tag, obs_main(), sbq.pop_front());
      end
   endtask

   task automatic core_pulse(input string tag);
      #2 core = 1'b0;
      #1 check({tag, "_async"}, obs_main(), 7'b0);
      @(posedge clk); #1;
      check({tag, "_held"}, obs_main(), 7'b0);
      @(negedge clk);
      core = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit, %0d checks", nchecks);
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      dla = 1'b0; direct = 1'b0; core = 1'b0;
      dla6 = 1'b0;
      #1;
      check("reset_main", obs_main(), 7'b0);
      check("reset_d6", obs6(), 7'b0);

      // Default staggered release
      @(negedge clk);
      dla = 1'b1; direct = 1'b1; core = 1'b1;
      seq_check("seq1", 1, 14);

      // Core reset pulse after DONE, then again mid-sequence once synced = 001
      core_pulse("core_done");
      seq_check("seq2a", 1, 7);
      core_pulse("core_mid");
      req = 3'b111;
      seq_check("seq2_req_ignored", 1, 10);
      req = 3'b000;
      seq_check("seq2_tail", 11, 14);

      // Single soft reset, then held requests on two domains
      soft_check("soft_single", 3'b010, 1, 6);
      soft_check("soft_held", 3'b101, 12, 16);

      // Async assert during a soft reset clears everything
      @(negedge clk);
      req = 3'b001;
      @(posedge clk); #1;
      req = 3'b000;
      check("soft_start", obs_main(), {1'b1, 3'b001, 3'b110});
      #2 dla = 1'b0;
      #1 check("soft_async_clr", obs_main(), 7'b0);

      // Test mode bypass
      @(negedge clk);
      core = 1'b0; direct = 1'b0; tm = 1'b1;
      #1 check("tm_low", obs_main(), 7'b0);
      direct = 1'b1;
      #1 check("tm_high", obs_main(), {1'b1, 3'b000, 3'b111});
      repeat (3) @(posedge clk);
      #1 check("tm_high_clk", obs_main(), {1'b1, 3'b000, 3'b111});
      direct = 1'b0;
      #1 check("tm_low2", obs_main(), 7'b0);
      tm = 1'b0;

      // Single-domain instance: release, then an async assert mid-count
      @(negedge clk);
      dla6 = 1'b1;
      seq6_check("d6_seq", 5);
      @(negedge clk);
      dla6 = 1'b0;
      #1 check("d6_clr", obs6(), 7'b0);
      @(negedge clk);
      dla6 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("d6_midcount", obs6(), 7'b0);
      dla6 = 1'b0;
      #1 check("d6_async_mid", obs6(), 7'b0);
      @(posedge clk); #1;
      check("d6_held", obs6(), 7'b0);
      @(negedge clk);
      dla6 = 1'b1;
      seq6_check("d6_seq2", 5);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
      $finish;
   end

endmodule
